// File: rtl/timer_bank.sv
// N-channel down-counter/timer bank: one-shot, periodic, square and PWM modes,
// per-channel pending IRQ bits and a registered count readback mux.

module timer_ch #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step_i,
  input  logic             wr_sel_i,
  input  logic [1:0]       wr_reg_i,
  input  logic [CNT_W-1:0] wr_data_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] count_o,
  output logic             ch_o,
  output logic             pend_o,
  output logic             irq_en_o
);
  typedef enum logic [1:0] {
    M_ONESHOT  = 2'b00,
    M_PERIODIC = 2'b01,
    M_SQUARE   = 2'b10,
    M_PWM      = 2'b11
  } mode_e;

  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] reload_q, reload_d;
  logic [CNT_W-1:0] compare_q, compare_d;
  mode_e            mode_q, mode_d;
  logic             en_q, en_d;
  logic             irq_en_q, irq_en_d;
  logic             ch_q, ch_d;
  logic             pend_q, pend_d;
  logic             wr_rl, wr_cmp, wr_ctl;

  assign wr_rl  = wr_sel_i && (wr_reg_i == 2'd0);
  assign wr_cmp = wr_sel_i && (wr_reg_i == 2'd1);
  assign wr_ctl = wr_sel_i && (wr_reg_i == 2'd2);

  always_comb begin
    count_d   = count_q;
    reload_d  = reload_q;
    compare_d = compare_q;
    mode_d    = mode_q;
    en_d      = en_q;
    irq_en_d  = irq_en_q;
    ch_d      = ch_q;
    pend_d    = pend_q & ~clr_i;

    // Periodic pulse ends after one clk even when the channel is disabled.
    if (mode_q == M_PERIODIC) ch_d = 1'b0;
    if (mode_q == M_PWM && en_q) ch_d = (count_q < compare_q);

    // Reload/ctrl writes to this channel swallow a coincident step.
    if (step_i && en_q && !wr_rl && !wr_ctl) begin
      if (count_q != '0) begin
        count_d = count_q - 1'b1;
      end else begin
        pend_d = 1'b1;
        unique case (mode_q)
          M_ONESHOT:  begin en_d = 1'b0; ch_d = 1'b1; end
          M_PERIODIC: begin count_d = reload_q; ch_d = 1'b1; end
          M_SQUARE:   begin count_d = reload_q; ch_d = ~ch_q; end
          M_PWM:      count_d = reload_q;
        endcase
      end
    end

    if (wr_rl) begin
      reload_d = wr_data_i;
      count_d  = wr_data_i;
      ch_d     = 1'b0;
    end
    if (wr_cmp) compare_d = wr_data_i;
    if (wr_ctl) begin
      en_d     = wr_data_i[0];
      mode_d   = mode_e'(wr_data_i[2:1]);
      irq_en_d = wr_data_i[3];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q   <= '0;
      reload_q  <= '0;
      compare_q <= '0;
      mode_q    <= M_ONESHOT;
      en_q      <= 1'b0;
      irq_en_q  <= 1'b0;
      ch_q      <= 1'b0;
      pend_q    <= 1'b0;
    end else begin
      count_q   <= count_d;
      reload_q  <= reload_d;
      compare_q <= compare_d;
      mode_q    <= mode_d;
      en_q      <= en_d;
      irq_en_q  <= irq_en_d;
      ch_q      <= ch_d;
      pend_q    <= pend_d;
    end
  end

  assign count_o  = count_q;
  assign ch_o     = ch_q;
  assign pend_o   = pend_q;
  assign irq_en_o = irq_en_q;
endmodule

module timer_bank #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 32,
  parameter int CH_W  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  tick_in,
  input  logic             wr_en,
  input  logic [CH_W-1:0]  wr_ch,
  input  logic [1:0]       wr_reg,
  input  logic [CNT_W-1:0] wr_data,
  input  logic [CH_W-1:0]  rd_ch,
  output logic [CNT_W-1:0] cnt_out,
  output logic [N_CH-1:0]  ch_out,
  output logic [N_CH-1:0]  irq_pend,
  output logic             irq
);
  logic [N_CH-1:0]            tick_q, step, wr_sel, clr, irq_en;
  logic [N_CH-1:0][CNT_W-1:0] count;
  logic [CNT_W-1:0]           cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_q <= '0;
      cnt_q  <= '0;
    end else begin
      tick_q <= tick_in;
      cnt_q  <= cnt_d;
    end
  end

  assign step = tick_in & ~tick_q;
  assign clr  = (wr_en && wr_reg == 2'd3) ? wr_data[N_CH-1:0] : '0;

  // Decoding by equality against each lane makes out-of-range selects a no-op.
  always_comb begin
    wr_sel = '0;
    cnt_d  = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (wr_en && int'(wr_ch) == i) wr_sel[i] = 1'b1;
      if (int'(rd_ch) == i)          cnt_d     = count[i];
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    timer_ch #(.CNT_W(CNT_W)) u_ch (
      .clk       (clk),
      .rst       (rst),
      .step_i    (step[i]),
      .wr_sel_i  (wr_sel[i]),
      .wr_reg_i  (wr_reg),
      .wr_data_i (wr_data),
      .clr_i     (clr[i]),
      .count_o   (count[i]),
      .ch_o      (ch_out[i]),
      .pend_o    (irq_pend[i]),
      .irq_en_o  (irq_en[i])
    );
  end

  assign cnt_out = cnt_q;
  assign irq     = |(irq_pend & irq_en);
endmodule
